// File: rtl/cache_defs.sv
// Shared dcache definitions: line/tag geometry and the victim swap controller
// state and refill-source encodings.
package cache_defs;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DCACHE_TAG_BITS   = 24;
  localparam int VSC_CNT_W         = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE    = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    EVICT    = 3'd4,
    REFILL   = 3'd5
  } vsc_state_e;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_VC  = 1'b1
  } refill_src_e;

  // True in the states that own the victim-cache lookup/write port.
  function automatic logic vsc_uses_vc(input vsc_state_e st);
    return (st == PROBE) || (st == EVICT);
  endfunction

endpackage

// File: rtl/victim_swap_ctrl_sat_counter.sv
// Saturating event counter with a synchronous clear that dominates increment.
module sat_counter
  import cache_defs::*;
#(
  parameter int CNT_W = VSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/victim_swap_ctrl.sv
// Dcache miss-path controller: probes the victim cache, falls back to memory,
// writes the dcache eviction into the victim cache and refills the dcache.
module victim_swap_ctrl
  import cache_defs::*;
#(
  parameter int LINE_W = DCACHE_LINE_WIDTH,
  parameter int TAG_W  = DCACHE_TAG_BITS,
  parameter int CNT_W  = VSC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [TAG_W-1:0]  miss_tag,
  input  logic              evict_valid,
  input  logic [TAG_W-1:0]  evict_tag,
  input  logic [LINE_W-1:0] evict_data,
  output logic [TAG_W-1:0]  vc_tag,
  output logic              vc_write,
  output logic [LINE_W-1:0] vc_wdata,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              refill_valid,
  output logic [TAG_W-1:0]  refill_tag,
  output logic [LINE_W-1:0] refill_data,
  output logic              refill_from_vc,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  input  logic              cnt_clr
);

  vsc_state_e        state_r;
  vsc_state_e        state_next_s;
  logic              accept_s;
  logic              hit_inc_s;
  logic              miss_inc_s;
  logic [TAG_W-1:0]  vc_tag_next_s;

  logic [TAG_W-1:0]  miss_tag_r;
  logic              evict_valid_r;
  logic [TAG_W-1:0]  evict_tag_r;
  logic [LINE_W-1:0] evict_data_r;
  logic [LINE_W-1:0] line_r;
  refill_src_e       src_r;

  logic              miss_ready_r;
  logic [TAG_W-1:0]  vc_tag_r;
  logic              vc_write_r;
  logic              mem_req_valid_r;
  logic              refill_valid_r;

  // Next-state decode and per-cycle events.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (miss_valid) begin
          accept_s     = 1'b1;
          state_next_s = PROBE;
        end else begin
          state_next_s = IDLE;
        end
      end
      PROBE: begin
        if (vc_hit) begin
          hit_inc_s    = 1'b1;
          state_next_s = EVICT;
        end else begin
          miss_inc_s   = 1'b1;
          state_next_s = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) begin
          state_next_s = MEM_WAIT;
        end else begin
          state_next_s = MEM_REQ;
        end
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          state_next_s = EVICT;
        end else begin
          state_next_s = MEM_WAIT;
        end
      end
      EVICT:   state_next_s = REFILL;
      REFILL:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // The shared victim tag tracks the miss tag except while writing the eviction.
  always_comb begin
    vc_tag_next_s = miss_tag_r;
    if (accept_s) begin
      vc_tag_next_s = miss_tag;
    end else if (state_next_s == EVICT) begin
      vc_tag_next_s = evict_tag_r;
    end else begin
      vc_tag_next_s = miss_tag_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Miss/eviction latches and the refill line buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_tag_r    <= {TAG_W{1'b0}};
      evict_valid_r <= 1'b0;
      evict_tag_r   <= {TAG_W{1'b0}};
      evict_data_r  <= {LINE_W{1'b0}};
      line_r        <= {LINE_W{1'b0}};
      src_r         <= SRC_MEM;
    end else begin
      if (accept_s) begin
        miss_tag_r    <= miss_tag;
        evict_valid_r <= evict_valid;
        evict_tag_r   <= evict_tag;
        evict_data_r  <= evict_data;
      end
      if ((state_r == PROBE) && vc_hit) begin
        line_r <= vc_rdata;
        src_r  <= SRC_VC;
      end else if ((state_r == MEM_WAIT) && mem_rsp_valid) begin
        line_r <= mem_rsp_data;
        src_r  <= SRC_MEM;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_ready_r    <= 1'b1;
      vc_tag_r        <= {TAG_W{1'b0}};
      vc_write_r      <= 1'b0;
      mem_req_valid_r <= 1'b0;
      refill_valid_r  <= 1'b0;
    end else begin
      miss_ready_r    <= (state_next_s == IDLE);
      vc_tag_r        <= vc_tag_next_s;
      vc_write_r      <= (state_next_s == EVICT) && evict_valid_r;
      mem_req_valid_r <= (state_next_s == MEM_REQ);
      refill_valid_r  <= (state_next_s == REFILL);
    end
  end

  assign miss_ready     = miss_ready_r;
  assign vc_tag         = vc_tag_r;
  assign vc_write       = vc_write_r;
  assign vc_wdata       = evict_data_r;
  assign mem_req_valid  = mem_req_valid_r;
  assign mem_req_tag    = miss_tag_r;
  assign refill_valid   = refill_valid_r;
  assign refill_tag     = miss_tag_r;
  assign refill_data    = line_r;
  assign refill_from_vc = (src_r == SRC_VC);

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc_s),
    .clr (cnt_clr),
    .cnt (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (miss_inc_s),
    .clr (cnt_clr),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Directed bench for victim_swap_ctrl with a one-entry victim cache model.
module tb_victim_swap_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [23:0]  miss_tag = 24'h0;
  logic         evict_valid = 1'b0;
  logic [23:0]  evict_tag = 24'h0;
  logic [127:0] evict_data = 128'h0;
  logic [23:0]  vc_tag;
  logic         vc_write;
  logic [127:0] vc_wdata;
  logic         vc_hit;
  logic [127:0] vc_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [23:0]  mem_req_tag;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = 128'h0;
  logic         refill_valid;
  logic [23:0]  refill_tag;
  logic [127:0] refill_data;
  logic         refill_from_vc;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
  logic         cnt_clr = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] D_DEAD = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
  localparam logic [127:0] D_BEEF = 128'hBEEFBEEF_BEEFBEEF_BEEFBEEF_BEEFBEEF;
  localparam logic [127:0] D_CAFE = 128'hCAFECAFE_CAFECAFE_CAFECAFE_CAFECAFE;
  localparam logic [127:0] D_1111 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] D_2222 = 128'h22222222_22222222_22222222_22222222;

  // One-entry victim cache: combinational lookup, written on vc_write.
  logic [23:0]  ent_tag  = 24'h0000A5;
  logic [127:0] ent_data = D_DEAD;
  assign vc_hit   = (vc_tag == ent_tag);
  assign vc_rdata = ent_data;
  always @(posedge clk) begin
    if (vc_write) begin
      ent_tag  <= vc_tag;
      ent_data <= vc_wdata;
    end
  end

  always #5 clk = ~clk;

  victim_swap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_ready     (miss_ready),
    .miss_tag       (miss_tag),
    .evict_valid    (evict_valid),
    .evict_tag      (evict_tag),
    .evict_data     (evict_data),
    .vc_tag         (vc_tag),
    .vc_write       (vc_write),
    .vc_wdata       (vc_wdata),
    .vc_hit         (vc_hit),
    .vc_rdata       (vc_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_tag    (mem_req_tag),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .refill_valid   (refill_valid),
    .refill_tag     (refill_tag),
    .refill_data    (refill_data),
    .refill_from_vc (refill_from_vc),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .cnt_clr        (cnt_clr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_miss_ready", 128'(miss_ready), 128'd1);
    check("rst_vc_tag", 128'(vc_tag), 128'd0);
    check("rst_vc_write", 128'(vc_write), 128'd0);
    check("rst_mem_req_valid", 128'(mem_req_valid), 128'd0);
    check("rst_refill_valid", 128'(refill_valid), 128'd0);
    check("rst_refill_data", refill_data, 128'd0);
    check("rst_refill_from_vc", 128'(refill_from_vc), 128'd0);
    check("rst_hit_cnt", 128'(hit_cnt), 128'd0);
    check("rst_miss_cnt", 128'(miss_cnt), 128'd0);
    @(negedge clk);

    // Victim hit on 0xA5, evicting 0xB7
    miss_valid = 1'b1; miss_tag = 24'h0000A5;
    evict_valid = 1'b1; evict_tag = 24'h0000B7; evict_data = D_BEEF;
    step();
    miss_valid = 1'b0; evict_valid = 1'b0;
    check("hit_probe_ready", 128'(miss_ready), 128'd0);
    check("hit_probe_tag", 128'(vc_tag), 128'h0000A5);
    check("hit_probe_write", 128'(vc_write), 128'd0);
    step();
    check("hit_evict_write", 128'(vc_write), 128'd1);
    check("hit_evict_tag", 128'(vc_tag), 128'h0000B7);
    check("hit_evict_wdata", vc_wdata, D_BEEF);
    check("hit_evict_norefill", 128'(refill_valid), 128'd0);
    check("hit_cnt_1", 128'(hit_cnt), 128'd1);
    step();
    check("hit_refill_valid", 128'(refill_valid), 128'd1);
    check("hit_refill_data", refill_data, D_DEAD);
    check("hit_refill_tag", 128'(refill_tag), 128'h0000A5);
    check("hit_refill_src", 128'(refill_from_vc), 128'd1);
    check("hit_refill_nowrite", 128'(vc_write), 128'd0);
    step();
    check("hit_done_refill", 128'(refill_valid), 128'd0);
    check("hit_done_ready", 128'(miss_ready), 128'd1);
    check("hit_done_vc_tag", 128'(vc_tag), 128'h0000A5);

    // Victim miss on 0x123, slow memory
    miss_valid = 1'b1; miss_tag = 24'h000123;
    evict_valid = 1'b1; evict_tag = 24'h0000C3; evict_data = D_1111;
    step();
    miss_valid = 1'b0; evict_valid = 1'b0;
    check("miss_probe_req", 128'(mem_req_valid), 128'd0);
    step();
    check("miss_req_valid0", 128'(mem_req_valid), 128'd1);
    check("miss_req_tag0", 128'(mem_req_tag), 128'h000123);
    check("miss_cnt_1", 128'(miss_cnt), 128'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = D_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    check("miss_req_valid1", 128'(mem_req_valid), 128'd1);
    check("miss_req_tag1", 128'(mem_req_tag), 128'h000123);
    check("miss_req_no_early_refill", 128'(refill_valid), 128'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("miss_wait_req_drop", 128'(mem_req_valid), 128'd0);
    repeat (3) begin
      step();
      check("miss_wait_idle", 128'({vc_write, refill_valid}), 128'd0);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = D_CAFE;
    step();
    mem_rsp_valid = 1'b0;
    check("miss_evict_write", 128'(vc_write), 128'd1);
    check("miss_evict_tag", 128'(vc_tag), 128'h0000C3);
    step();
    check("miss_refill_valid", 128'(refill_valid), 128'd1);
    check("miss_refill_data", refill_data, D_CAFE);
    check("miss_refill_tag", 128'(refill_tag), 128'h000123);
    check("miss_refill_src", 128'(refill_from_vc), 128'd0);
    check("miss_hit_cnt", 128'(hit_cnt), 128'd1);
    step();

    // Victim hit on 0xC3 without eviction; next miss queued during REFILL
    miss_valid = 1'b1; miss_tag = 24'h0000C3;
    evict_valid = 1'b0; evict_tag = 24'h0000D1; evict_data = D_2222;
    step();
    miss_valid = 1'b0;
    step();
    check("noev_no_write", 128'(vc_write), 128'd0);
    miss_valid = 1'b1; miss_tag = 24'h000200; evict_valid = 1'b0;
    step();
    check("noev_refill_valid", 128'(refill_valid), 128'd1);
    check("noev_refill_data", refill_data, D_1111);
    check("noev_refill_src", 128'(refill_from_vc), 128'd1);
    step();
    check("b2b_ready", 128'(miss_ready), 128'd1);
    check("b2b_refill_drop", 128'(refill_valid), 128'd0);

    // Miss on 0x200, reset while in MEM_WAIT with miss_valid held
    step();
    miss_tag = 24'h0002FF;
    check("busy_ready", 128'(miss_ready), 128'd0);
    step();
    check("rstmid_req_tag", 128'(mem_req_tag), 128'h000200);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    check("rstmid_tag_not_resampled", 128'(mem_req_tag), 128'h000200);
    check("rstmid_miss_cnt", 128'(miss_cnt), 128'd2);
    rst = 1'b0;
    miss_valid = 1'b0;
    #1;
    check("rstmid_ready", 128'(miss_ready), 128'd1);
    check("rstmid_no_refill", 128'(refill_valid), 128'd0);
    check("rstmid_no_write", 128'(vc_write), 128'd0);
    check("rstmid_hit_cnt", 128'(hit_cnt), 128'd0);
    step();
    rst = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = D_CAFE;
    step();
    mem_rsp_valid = 1'b0;
    check("rstmid_after_idle", 128'({refill_valid, vc_write, mem_req_valid}), 128'd0);

    // Normal hit after the abort
    miss_valid = 1'b1; miss_tag = 24'h0000C3;
    evict_valid = 1'b1; evict_tag = 24'h0000E5; evict_data = D_2222;
    step();
    miss_valid = 1'b0; evict_valid = 1'b0;
    step();
    check("post_evict_write", 128'(vc_write), 128'd1);
    check("post_evict_tag", 128'(vc_tag), 128'h0000E5);
    step();
    check("post_refill_data", refill_data, D_1111);
    check("post_refill_tag", 128'(refill_tag), 128'h0000C3);
    check("post_hit_cnt", 128'(hit_cnt), 128'd1);
    step();

    // Saturation, then clear racing an increment
    force dut.u_hit_cnt.cnt_r = 16'hFFFF;
    #1;
    release dut.u_hit_cnt.cnt_r;
    #1;
    check("sat_preload", 128'(hit_cnt), 128'hFFFF);
    miss_valid = 1'b1; miss_tag = 24'h0000E5; evict_valid = 1'b0;
    step();
    miss_valid = 1'b0;
    step();
    check("sat_hold", 128'(hit_cnt), 128'hFFFF);
    step();
    check("sat_refill_data", refill_data, D_2222);
    step();
    miss_valid = 1'b1;
    step();
    miss_valid = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_hit_cnt", 128'(hit_cnt), 128'd0);
    check("clr_miss_cnt", 128'(miss_cnt), 128'd0);
    step();
    check("clr_refill_valid", 128'(refill_valid), 128'd1);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
